// File: rtl/hall_feedback_decoder.sv
// Hall-sensor receive path: synchronise and glitch-filter the raw {C,B,A}
// code, decode the 6-step electrical position and rotation direction,
// measure the commutation period and flag stalls and sensor faults.
//
// Handshake note: there is no valid/ready flow control on this block.
// Every per-transition output (step, hall_valid, direction, period,
// period_valid, hall_error) is updated on the same edge that raises the
// one-cycle commutation_pulse, so a consumer may sample them whenever the
// pulse is high.
module hall_feedback_decoder #(
    parameter int FILTER_LEN   = 4,
    parameter int PERIOD_WIDTH = 20,
    parameter int TIMEOUT      = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              hall_signal,
    output logic [2:0]              step,
    output logic                    hall_valid,
    output logic                    direction,
    output logic                    commutation_pulse,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    no_feedback,
    output logic                    hall_error
);

    typedef enum logic [1:0] {
        WAIT_FIRST  = 2'd0,
        WAIT_SECOND = 2'd1,
        RUNNING     = 2'd2
    } state_t;

    localparam logic [7:0]              FILT_LAST  = 8'(FILTER_LEN - 1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE    = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] STALL_LAST = PERIOD_WIDTH'(TIMEOUT - 1);
    localparam logic [PERIOD_WIDTH-1:0] STALL_TOP  = PERIOD_WIDTH'(TIMEOUT);

    logic [2:0]              sync1_q;
    logic [2:0]              sync2_q;
    logic [2:0]              cand_q;
    logic [7:0]              filt_cnt_q;
    logic [2:0]              filt_q;
    logic [PERIOD_WIDTH-1:0] period_cnt_q;
    logic [PERIOD_WIDTH-1:0] stall_cnt_q;
    state_t                  state_q;
    state_t                  state_d;

    logic       accept;
    logic       new_legal;
    logic [2:0] new_step;
    logic       step_fwd;
    logic       step_rev;
    logic       timeout_hit;
    logic       load_period;
    logic       raise_error;
    logic       clear_pv;

    // Code-to-position map in forward rotation order; illegal codes map to 0.
    function automatic logic [2:0] code_to_step(input logic [2:0] code);
        case (code)
            3'b001:  code_to_step = 3'd0;
            3'b011:  code_to_step = 3'd1;
            3'b010:  code_to_step = 3'd2;
            3'b110:  code_to_step = 3'd3;
            3'b100:  code_to_step = 3'd4;
            3'b101:  code_to_step = 3'd5;
            default: code_to_step = 3'd0;
        endcase
    endfunction

    // A candidate that has held for FILTER_LEN samples and differs from the
    // current filtered code is an accepted transition. The current step
    // output is the reference position for adjacency.
    always_comb begin
        accept      = (filt_cnt_q == FILT_LAST) && (cand_q != filt_q);
        new_legal   = (cand_q != 3'b000) && (cand_q != 3'b111);
        new_step    = code_to_step(cand_q);
        step_fwd    = (new_step == ((step == 3'd5) ? 3'd0 : step + 3'd1));
        step_rev    = (new_step == ((step == 3'd0) ? 3'd5 : step - 3'd1));
        timeout_hit = !accept && (stall_cnt_q == STALL_LAST);
    end

    // Two-flop synchroniser followed by the candidate/stability filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            cand_q     <= 3'b000;
            filt_cnt_q <= 8'd0;
            filt_q     <= 3'b000;
        end else begin
            sync1_q <= hall_signal;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q     <= sync2_q;
                filt_cnt_q <= 8'd0;
            end else if (filt_cnt_q != FILT_LAST) begin
                filt_cnt_q <= filt_cnt_q + 8'd1;
            end
            if (accept) begin
                filt_q <= cand_q;
            end
        end
    end

    // Period and stall counters: both restart on every accepted transition
    // and saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (accept) begin
                period_cnt_q <= '0;
                stall_cnt_q  <= '0;
            end else begin
                if (period_cnt_q != CNT_MAX) begin
                    period_cnt_q <= period_cnt_q + CNT_ONE;
                end
                if (stall_cnt_q != STALL_TOP) begin
                    stall_cnt_q <= stall_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus the per-transition decisions. An accepted
    // transition takes priority over a timeout landing on the same edge.
    always_comb begin
        state_d     = state_q;
        load_period = 1'b0;
        raise_error = 1'b0;
        clear_pv    = 1'b0;
        if (accept) begin
            if (!new_legal) begin
                raise_error = 1'b1;
                clear_pv    = 1'b1;
                state_d     = WAIT_FIRST;
            end else begin
                case (state_q)
                    WAIT_FIRST: begin
                        state_d = WAIT_SECOND;
                    end
                    WAIT_SECOND, RUNNING: begin
                        if (step_fwd || step_rev) begin
                            load_period = 1'b1;
                            state_d     = RUNNING;
                        end else begin
                            raise_error = 1'b1;
                            clear_pv    = 1'b1;
                            state_d     = WAIT_SECOND;
                        end
                    end
                    default: begin
                        state_d = WAIT_FIRST;
                    end
                endcase
            end
        end else if (timeout_hit) begin
            clear_pv = 1'b1;
            state_d  = WAIT_FIRST;
        end
    end

    // Registered outputs, all updated on the edge of the accepted transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step              <= 3'd0;
            hall_valid        <= 1'b0;
            direction         <= 1'b0;
            commutation_pulse <= 1'b0;
            period            <= '0;
            period_valid      <= 1'b0;
            no_feedback       <= 1'b0;
            hall_error        <= 1'b0;
        end else begin
            commutation_pulse <= accept;
            hall_error        <= raise_error;
            if (accept) begin
                hall_valid <= new_legal;
                if (new_legal) begin
                    step <= new_step;
                end
            end
            if (load_period) begin
                period       <= (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
                direction    <= step_fwd;
                period_valid <= 1'b1;
            end else if (clear_pv) begin
                period_valid <= 1'b0;
            end
            if (accept && new_legal) begin
                no_feedback <= 1'b0;
            end else if (timeout_hit) begin
                no_feedback <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hall_feedback_decoder.sv
// Bench for hall_feedback_decoder: directed Hall sequences followed by a
// randomized phase, compared each cycle against an event-level model.
module tb_hall_feedback_decoder;

  localparam int FL      = 4;
  localparam int PW      = 20;
  localparam int TO      = 5000;
  localparam int PER_MAX = (1 << PW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    hall_signal = 3'b001;
  logic [2:0]    step;
  logic          hall_valid;
  logic          direction;
  logic          commutation_pulse;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          no_feedback;
  logic          hall_error;

  always #5 clk = ~clk;

  hall_feedback_decoder #(.FILTER_LEN(FL), .PERIOD_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .hall_signal(hall_signal),
    .step(step),
    .hall_valid(hall_valid),
    .direction(direction),
    .commutation_pulse(commutation_pulse),
    .period(period),
    .period_valid(period_valid),
    .no_feedback(no_feedback),
    .hall_error(hall_error)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Position of each code in forward order, and codes by position.
  int         step_of [8] = '{0, 0, 2, 1, 4, 5, 3, 0};
  logic [2:0] code_of [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  // ---------------- reference model ----------------
  // A code is accepted once FL consecutive samples agree, seen through a
  // three-edge pipeline; the rest is evaluated per accepted event.
  logic [2:0]  hist[$];
  logic [25:0] exp_q[$];
  int          n;
  int          last_acc;
  logic [2:0]  m_filt;
  bit          m_ref;
  int          exp_step;
  bit          exp_dir, exp_pv, exp_nf, exp_hv, exp_pulse, exp_err;
  int          exp_period;

  // DUT-side observations for directed checks
  int pulse_cnt = 0;
  int err_cnt   = 0;
  int last_pulse_n = 0;
  int nf_rise_n    = -1;

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(3'b000);
    exp_q.delete();
    n = 0; last_acc = 0; m_filt = 3'b000; m_ref = 0;
    exp_step = 0; exp_dir = 0; exp_pv = 0; exp_nf = 0; exp_hv = 0;
    exp_pulse = 0; exp_err = 0; exp_period = 0;
  endtask

  task automatic model_edge();
    bit         acc, same;
    logic [2:0] v;
    int         s, d;
    n++;
    hist.push_back(hall_signal);
    if (hist.size() > FL + 3) void'(hist.pop_front());
    acc = 0;
    v   = 3'b000;
    if (hist.size() == FL + 3) begin
      v = hist[FL-1];
      same = 1;
      for (int i = 0; i < FL; i++) if (hist[i] != v) same = 0;
      if (same && v != m_filt) acc = 1;
    end
    exp_pulse = acc;
    exp_err   = 0;
    if (acc) begin
      m_filt = v;
      exp_hv = (v != 3'b000) && (v != 3'b111);
      if (!exp_hv) begin
        exp_err = 1; exp_pv = 0; m_ref = 0;
      end else begin
        s = step_of[v];
        exp_nf = 0;
        if (m_ref) begin
          d = (s - exp_step + 6) % 6;
          if (d == 1 || d == 5) begin
            exp_period = (n - last_acc > PER_MAX) ? PER_MAX : n - last_acc;
            exp_pv  = 1;
            exp_dir = (d == 1);
          end else begin
            exp_err = 1; exp_pv = 0;
          end
        end
        m_ref = 1;
        exp_step = s;
      end
      last_acc = n;
      exp_q.push_back({exp_dir, exp_pv, PW'(exp_period), exp_hv ? 3'(exp_step) : 3'd0, exp_hv});
    end else if (n - last_acc == TO) begin
      exp_nf = 1; exp_pv = 0; m_ref = 0;
    end
  endtask

  // Model update on each edge, compare 1 time unit later.
  always @(posedge clk) begin
    if (reset) model_reset();
    else model_edge();
    #1;
    if (reset) begin
      check("rst_step", step, 0);
      check("rst_hv", hall_valid, 0);
      check("rst_dir", direction, 0);
      check("rst_pulse", commutation_pulse, 0);
      check("rst_period", period, 0);
      check("rst_pv", period_valid, 0);
      check("rst_nf", no_feedback, 0);
      check("rst_err", hall_error, 0);
    end else begin
      check("pulse", commutation_pulse, exp_pulse);
      check("hall_error", hall_error, exp_err);
      check("no_feedback", no_feedback, exp_nf);
      check("period_valid", period_valid, exp_pv);
      if (commutation_pulse) begin
        pulse_cnt++;
        last_pulse_n = n;
        if (exp_q.size() == 0) check("trans_unexpected", 1, 0);
        else check("trans", {direction, period_valid, period, hall_valid ? step : 3'd0, hall_valid},
                   exp_q.pop_front());
      end
      if (hall_error) err_cnt++;
      if (no_feedback && nf_rise_n < 0) nf_rise_n = n;
    end
  end

  // ---------------- driver tasks ----------------
  logic [2:0] cur_code = 3'b001;

  task automatic drive(input logic [2:0] code, input int cycles);
    hall_signal = code;
    cur_code = code;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int p0, e0, r, pos;
  logic [2:0] code;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // forward rotation, 100-cycle spacing
    e0 = err_cnt;
    for (int i = 0; i < 12; i++) drive(code_of[i % 6], 100);
    check("fwd_period", period, 100);
    check("fwd_dir", direction, 1);
    check("fwd_pv", period_valid, 1);
    check("fwd_no_err", err_cnt - e0, 0);

    // reverse rotation, 250-cycle spacing (first step is a mid-run reversal)
    e0 = err_cnt;
    for (int i = 4; i >= -1; i--) drive(code_of[(i + 6) % 6], 250);
    check("rev_period", period, 250);
    check("rev_dir", direction, 0);
    check("rev_no_err", err_cnt - e0, 0);

    // forward again to 011, then a 3-cycle 111 glitch
    drive(3'b001, 250);
    drive(3'b011, 250);
    p0 = pulse_cnt; e0 = err_cnt;
    drive(3'b111, 3);
    drive(3'b011, 100);
    check("glitch_pulses", pulse_cnt - p0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_period", period, 250);

    // held illegal code
    e0 = err_cnt;
    drive(3'b111, 10);
    drive(3'b111, 10);
    check("ill_err", err_cnt - e0, 1);
    check("ill_hv", hall_valid, 0);
    check("ill_pv", period_valid, 0);
    drive(3'b011, 100);
    check("ill_next_hv", hall_valid, 1);
    check("ill_next_pv", period_valid, 0);
    drive(3'b010, 100);
    check("ill_second_pv", period_valid, 1);

    // skipped step while running
    drive(3'b011, 100);
    drive(3'b001, 100);
    e0 = err_cnt;
    drive(3'b010, 100);
    check("skip_err", err_cnt - e0, 1);
    check("skip_pv", period_valid, 0);
    drive(3'b110, 100);
    check("skip_recover_pv", period_valid, 1);

    // stall
    nf_rise_n = -1;
    for (int i = 0; i < TO + 200 && !no_feedback; i++) @(negedge clk);
    check("stall_nf", no_feedback, 1);
    check("stall_time", nf_rise_n - last_pulse_n, TO);
    drive(3'b100, 20);
    check("stall_clear_nf", no_feedback, 0);
    check("stall_clear_pv", period_valid, 0);

    // asynchronous reset mid-run
    drive(3'b101, 100);
    drive(3'b001, 30);
    #2 reset = 1'b1;
    #1;
    check("arst_step", step, 0);
    check("arst_hv", hall_valid, 0);
    check("arst_period", period, 0);
    check("arst_pv", period_valid, 0);
    check("arst_dir", direction, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // randomized phase, biased towards adjacent steps
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7 && cur_code != 3'b000 && cur_code != 3'b111) begin
        pos = (step_of[cur_code] + ((r < 5) ? 1 : 5)) % 6;
        code = code_of[pos];
      end else begin
        code = 3'($urandom_range(0, 7));
      end
      drive(code, $urandom_range(1, 30));
    end
    drive(cur_code, 20);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
